// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one data RAM port between the CPU data port (m0) and a
// DMA/debug loader (m1). Each access takes three cycles: a grant cycle in
// IDLE, one ACCESS cycle with the RAM enabled, and one RESPOND cycle with
// the ack pulse.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   m0_* / m1_*         requester fields in; read_data/ack out; m0_stall out
//   ram_*               registered RAM bus out; ram_read_data in
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request; arbitration happens here
// ACCESS  | RAM enabled with the granted fields; read data captured
// RESPOND | granted ack high; requests ignored so none is double-served
module ram_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = 4,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_operation,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [SEL_WIDTH-1:0]  m0_select_signal,
  input  logic [DATA_WIDTH-1:0] m0_write_data,
  output logic [DATA_WIDTH-1:0] m0_read_data,
  output logic                  m0_ack,
  output logic                  m0_stall,
  input  logic                  m1_req,
  input  logic                  m1_operation,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [SEL_WIDTH-1:0]  m1_select_signal,
  input  logic [DATA_WIDTH-1:0] m1_write_data,
  output logic [DATA_WIDTH-1:0] m1_read_data,
  output logic                  m1_ack,
  output logic                  ram_chip_enable,
  output logic                  ram_operation,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [SEL_WIDTH-1:0]  ram_select_signal,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic [DATA_WIDTH-1:0] ram_read_data
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} state_t;

  state_t                state_q, state_d;
  logic                  grant_q, grant_d;          // 1 = m1 owns the access
  logic                  last_grant_q, last_grant_d;
  logic                  ce_q, ce_d;
  logic                  op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  m0_ack_q, m0_ack_d;
  logic                  m1_ack_q, m1_ack_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic                  pick_m1;

  // State register and all datapath flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;  // m0 wins the first round-robin tie
      ce_q         <= 1'b0;
      op_q         <= 1'b0;
      addr_q       <= '0;
      sel_q        <= '0;
      wdata_q      <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ce_q         <= ce_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      sel_q        <= sel_d;
      wdata_q      <= wdata_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (m0_req || m1_req) state_d = S_ACCESS;
      S_ACCESS:  state_d = S_RESPOND;
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // On a tie, round-robin grants whoever did not win last time.
  always_comb begin
    if (m0_req && m1_req) begin
      pick_m1 = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant_q;
    end else begin
      pick_m1 = m1_req;
    end
  end

  // Output / datapath logic. Bus fields hold between accesses; only the
  // enable and the acks fall back to zero.
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ce_d         = 1'b0;
    op_d         = op_q;
    addr_d       = addr_q;
    sel_d        = sel_q;
    wdata_d      = wdata_q;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          grant_d      = pick_m1;
          last_grant_d = pick_m1;
          ce_d         = 1'b1;
          op_d         = pick_m1 ? m1_operation     : m0_operation;
          addr_d       = pick_m1 ? m1_addr          : m0_addr;
          sel_d        = pick_m1 ? m1_select_signal : m0_select_signal;
          wdata_d      = pick_m1 ? m1_write_data    : m0_write_data;
        end
      end
      S_ACCESS: begin
        if (!op_q) begin
          if (grant_q) m1_rdata_d = ram_read_data;
          else         m0_rdata_d = ram_read_data;
        end
        if (grant_q) m1_ack_d = 1'b1;
        else         m0_ack_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign ram_chip_enable   = ce_q;
  assign ram_operation     = op_q;
  assign ram_addr          = addr_q;
  assign ram_select_signal = sel_q;
  assign ram_write_data    = wdata_q;
  assign m0_ack            = m0_ack_q;
  assign m1_ack            = m1_ack_q;
  assign m0_read_data      = m0_rdata_q;
  assign m1_read_data      = m1_rdata_q;
  assign m0_stall          = m0_req & ~m0_ack_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: instance 0 is round-robin, instance 1 fixed-priority,
// both driven by the same requester stimulus, each with its own RAM.
module tb_ram_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, mem_init;
  logic        m0_req, m0_op, m1_req, m1_op;
  logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
  logic [3:0]  m0_sel, m1_sel;

  logic [31:0] m0_rd [2], m1_rd [2], ram_addr [2], ram_wd [2], ram_rd [2];
  logic        m0_ack [2], m1_ack [2], m0_stall [2], ram_ce [2], ram_op [2];
  logic [3:0]  ram_sel [2];

  int n_pass = 0;
  int n_total = 0;

  ram_arbiter #(.FIXED_PRIORITY(0)) u_rr (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_operation(m0_op), .m0_addr(m0_addr),
    .m0_select_signal(m0_sel), .m0_write_data(m0_wd),
    .m0_read_data(m0_rd[0]), .m0_ack(m0_ack[0]), .m0_stall(m0_stall[0]),
    .m1_req(m1_req), .m1_operation(m1_op), .m1_addr(m1_addr),
    .m1_select_signal(m1_sel), .m1_write_data(m1_wd),
    .m1_read_data(m1_rd[0]), .m1_ack(m1_ack[0]),
    .ram_chip_enable(ram_ce[0]), .ram_operation(ram_op[0]), .ram_addr(ram_addr[0]),
    .ram_select_signal(ram_sel[0]), .ram_write_data(ram_wd[0]), .ram_read_data(ram_rd[0]));

  ram_arbiter #(.FIXED_PRIORITY(1)) u_fp (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_operation(m0_op), .m0_addr(m0_addr),
    .m0_select_signal(m0_sel), .m0_write_data(m0_wd),
    .m0_read_data(m0_rd[1]), .m0_ack(m0_ack[1]), .m0_stall(m0_stall[1]),
    .m1_req(m1_req), .m1_operation(m1_op), .m1_addr(m1_addr),
    .m1_select_signal(m1_sel), .m1_write_data(m1_wd),
    .m1_read_data(m1_rd[1]), .m1_ack(m1_ack[1]),
    .ram_chip_enable(ram_ce[1]), .ram_operation(ram_op[1]), .ram_addr(ram_addr[1]),
    .ram_select_signal(ram_sel[1]), .ram_write_data(ram_wd[1]), .ram_read_data(ram_rd[1]));

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // RAM instances: combinational read while enabled, write at the clock edge.
  logic [31:0] mem [2][64];
  assign ram_rd[0] = ram_ce[0] ? mem[0][ram_addr[0][7:2]] : 32'h0;
  assign ram_rd[1] = ram_ce[1] ? mem[1][ram_addr[1][7:2]] : 32'h0;

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_init) begin
        for (int j = 0; j < 64; j++) mem[i][j] = 32'h0;
        mem[i][4] = 32'hDEADBEEF;
      end else if (ram_ce[i] && ram_op[i]) begin
        mem[i][ram_addr[i][7:2]] = merge(mem[i][ram_addr[i][7:2]], ram_wd[i], ram_sel[i]);
      end
    end
  end

  // Transaction-level model: a grant starts a 3-cycle transaction whose
  // second edge commits the access and raises the ack for one cycle.
  logic [31:0] mmem [2][64];
  logic        e_ce [2], e_op [2], e_ack0 [2], e_ack1 [2], e_last [2], busy [2], who [2];
  logic [31:0] e_addr [2], e_wd [2], e_rd0 [2], e_rd1 [2];
  logic [3:0]  e_sel [2];
  int          age [2];
  logic        mvalid;

  always @(posedge clock) begin : model
    logic w;
    if (mem_init) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 64; j++) mmem[i][j] = 32'h0;
        mmem[i][4] = 32'hDEADBEEF;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        mvalid = 1'b1;
        e_ce[i] = 0; e_op[i] = 0; e_addr[i] = 0; e_sel[i] = 0; e_wd[i] = 0;
        e_ack0[i] = 0; e_ack1[i] = 0; e_rd0[i] = 0; e_rd1[i] = 0;
        e_last[i] = 1'b1; busy[i] = 1'b0; age[i] = 0; who[i] = 1'b0;
      end else if (!busy[i]) begin
        if (m0_req || m1_req) begin
          if (m0_req && m1_req) w = (i == 1) ? 1'b0 : ~e_last[i];
          else                  w = m1_req;
          who[i] = w; e_last[i] = w; e_ce[i] = 1'b1;
          e_op[i]   = w ? m1_op   : m0_op;
          e_addr[i] = w ? m1_addr : m0_addr;
          e_sel[i]  = w ? m1_sel  : m0_sel;
          e_wd[i]   = w ? m1_wd   : m0_wd;
          busy[i] = 1'b1; age[i] = 0;
        end
      end else begin
        age[i]++;
        if (age[i] == 1) begin
          e_ce[i] = 1'b0;
          if (e_op[i]) mmem[i][e_addr[i][7:2]] = merge(mmem[i][e_addr[i][7:2]], e_wd[i], e_sel[i]);
          else if (who[i]) e_rd1[i] = mmem[i][e_addr[i][7:2]];
          else             e_rd0[i] = mmem[i][e_addr[i][7:2]];
          if (who[i]) e_ack1[i] = 1'b1;
          else        e_ack0[i] = 1'b1;
        end else begin
          e_ack0[i] = 1'b0; e_ack1[i] = 1'b0; busy[i] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clock) begin
    if (mvalid === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d.ram_chip_enable", i), 32'(ram_ce[i]), 32'(e_ce[i]));
        chk($sformatf("u%0d.ram_operation", i), 32'(ram_op[i]), 32'(e_op[i]));
        chk($sformatf("u%0d.ram_addr", i), ram_addr[i], e_addr[i]);
        chk($sformatf("u%0d.ram_select", i), 32'(ram_sel[i]), 32'(e_sel[i]));
        chk($sformatf("u%0d.ram_write_data", i), ram_wd[i], e_wd[i]);
        chk($sformatf("u%0d.m0_ack", i), 32'(m0_ack[i]), 32'(e_ack0[i]));
        chk($sformatf("u%0d.m1_ack", i), 32'(m1_ack[i]), 32'(e_ack1[i]));
        chk($sformatf("u%0d.m0_read_data", i), m0_rd[i], e_rd0[i]);
        chk($sformatf("u%0d.m1_read_data", i), m1_rd[i], e_rd1[i]);
        chk($sformatf("u%0d.m0_stall", i), 32'(m0_stall[i]), 32'(m0_req & ~e_ack0[i]));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic op, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    m0_req = req; m0_op = op; m0_addr = a; m0_wd = d; m0_sel = s;
  endtask

  task automatic set_m1(input logic req, input logic op, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    m1_req = req; m1_op = op; m1_addr = a; m1_wd = d; m1_sel = s;
  endtask

  int q0 [$], t0 [$];
  int n0_fp, n1_fp;
  int exp_rr [4] = '{0, 1, 0, 1};
  int exp_t  [4] = '{2, 5, 8, 11};
  logic got;

  initial begin
    reset = 1'b1; mem_init = 1'b1;
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    step(); step();
    reset = 1'b0; mem_init = 1'b0;
    step(); step();
    chk("idle.ram_chip_enable", 32'(ram_ce[0]), 32'h0);
    chk("idle.ram_addr", ram_addr[0], 32'h0);
    chk("idle.m0_read_data", m0_rd[0], 32'h0);
    chk("idle.m0_stall", 32'(m0_stall[0]), 32'h0);

    // m0 read 0x10
    set_m0(1, 0, 32'h10, 0, 4'hF);
    step();
    chk("rd10.ram_chip_enable", 32'(ram_ce[0]), 32'h1);
    chk("rd10.ram_addr", ram_addr[0], 32'h10);
    chk("rd10.m0_stall", 32'(m0_stall[0]), 32'h1);
    step();
    chk("rd10.m0_ack", 32'(m0_ack[0]), 32'h1);
    chk("rd10.m0_read_data", m0_rd[0], 32'hDEADBEEF);
    chk("rd10.ram_chip_enable_off", 32'(ram_ce[0]), 32'h0);
    set_m0(0, 0, 32'h10, 0, 4'hF);
    step();
    chk("rd10.ack_one_cycle", 32'(m0_ack[0]), 32'h0);

    // m1 write 0x20, m0 reads it back
    set_m1(1, 1, 32'h20, 32'hCAFEF00D, 4'hF);
    step(); step();
    chk("wr20.m1_ack", 32'(m1_ack[0]), 32'h1);
    set_m1(0, 0, 0, 0, 0);
    step();
    set_m0(1, 0, 32'h20, 0, 4'hF);
    step(); step();
    chk("rd20.m0_read_data", m0_rd[0], 32'hCAFEF00D);
    set_m0(0, 0, 0, 0, 0);
    step();

    // m1 partial write of the low half, then m1 read
    set_m1(1, 1, 32'h20, 32'h11223344, 4'b0011);
    step(); step();
    set_m1(0, 0, 0, 0, 0);
    step();
    set_m1(1, 0, 32'h20, 0, 4'hF);
    step(); step();
    chk("rd20b.m1_read_data", m1_rd[0], 32'hCAFE3344);
    chk("rd20b.m0_read_data_held", m0_rd[0], 32'hCAFEF00D);
    set_m1(0, 0, 0, 0, 0);
    step();

    // both requesters held for 12 cycles
    set_m0(1, 0, 32'h10, 0, 4'hF);
    set_m1(1, 0, 32'h20, 0, 4'hF);
    n0_fp = 0; n1_fp = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (m0_ack[0]) begin q0.push_back(0); t0.push_back(k); end
      if (m1_ack[0]) begin q0.push_back(1); t0.push_back(k); end
      if (m0_ack[1]) n0_fp++;
      if (m1_ack[1]) n1_fp++;
    end
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    chk("rr.ack_count", 32'(q0.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < q0.size()) begin
        chk($sformatf("rr.grant%0d", k), 32'(q0[k]), 32'(exp_rr[k]));
        chk($sformatf("rr.ack_cycle%0d", k), 32'(t0[k]), 32'(exp_t[k]));
      end
    end
    chk("fp.m0_acks", 32'(n0_fp), 32'd4);
    chk("fp.m1_acks", 32'(n1_fp), 32'd0);
    step(); step();

    // reset during ACCESS aborts the access
    set_m0(1, 0, 32'h10, 0, 4'hF);
    step();
    chk("abort.in_access", 32'(ram_ce[0]), 32'h1);
    reset = 1'b1;
    m0_req = 1'b0;
    step();
    chk("abort.m0_ack", 32'(m0_ack[0]), 32'h0);
    chk("abort.ram_chip_enable", 32'(ram_ce[0]), 32'h0);
    chk("abort.ram_addr", ram_addr[0], 32'h0);
    reset = 1'b0;
    step();
    chk("abort.no_late_ack", 32'(m0_ack[0]), 32'h0);
    chk("abort.ce_low", 32'(ram_ce[0]), 32'h0);

    // first tie after reset goes to m0, then m1 is served
    set_m0(1, 0, 32'h10, 0, 4'hF);
    set_m1(1, 0, 32'h20, 0, 4'hF);
    step(); step();
    chk("tie.m0_ack", 32'(m0_ack[0]), 32'h1);
    chk("tie.m0_read_data", m0_rd[0], 32'hDEADBEEF);
    set_m0(0, 0, 0, 0, 0);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      if (m1_ack[0]) got = 1'b1;
    end
    chk("tie.m1_ack_wait", 32'(got), 32'h1);
    chk("tie.m1_read_data", m1_rd[0], 32'hCAFE3344);
    set_m1(0, 0, 0, 0, 0);
    step(); step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
